// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared types and constants for the 8259-style acknowledge sequencer
package pic_pkg;

    localparam int PIC_NLVL = 8;
    localparam int PIC_LW   = 3;
    localparam logic [PIC_LW-1:0] SPUR_LVL = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACK1,
        ST_GAP,
        ST_ACK2
    } ack_state_e;

    // 0 = highest priority; the level just after the lowest-priority pointer ranks first
    function automatic logic [PIC_LW-1:0] prio_rank(logic [PIC_LW-1:0] lvl, logic [PIC_LW-1:0] lp);
        return lvl - lp - 3'd1;
    endfunction

endpackage

// File: rtl/pic_prio_rotate.sv
// rtl/pic_prio_rotate.sv - rotating priority resolver: highest set request starting after lp
module pic_prio_rotate
    import pic_pkg::*;
(
    input  logic [PIC_NLVL-1:0] req,
    input  logic [PIC_LW-1:0]   lp,
    output logic                valid,
    output logic [PIC_LW-1:0]   lvl
);

    logic [PIC_LW-1:0] idx;

    // Scan from lowest to highest priority so the last hit is the winner
    always_comb begin
        valid = 1'b0;
        lvl   = '0;
        idx   = '0;
        for (int i = PIC_NLVL - 1; i >= 0; i--) begin
            idx = lp + 3'd1 + 3'(i);
            if (req[idx]) begin
                valid = 1'b1;
                lvl   = idx;
            end
        end
    end

endmodule

// File: rtl/pic_ack_sequencer.sv
// rtl/pic_ack_sequencer.sv - INTA handshake FSM, in-service register and rotating priority
module pic_ack_sequencer
    import pic_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  IRR,
    input  logic [7:0]  IMR,
    input  logic        NINTA,
    input  logic        EOI_STB,
    input  logic        EOI_SPEC,
    input  logic [2:0]  EOI_LVL,
    input  logic        AEOI,
    input  logic        ROT_EN,
    input  logic [4:0]  VEC_BASE,
    output logic        INT,
    output logic [7:0]  ISR,
    output logic [7:0]  IRR_CLR,
    output logic [7:0]  VEC,
    output logic        VEC_OE
);

    ack_state_e          state_q, state_d;
    logic                int_q, int_d;
    logic [7:0]          isr_q, isr_d;
    logic [7:0]          irr_clr_q, irr_clr_d;
    logic [7:0]          vec_q, vec_d;
    logic                vec_oe_q, vec_oe_d;
    logic [PIC_LW-1:0]   lp_q, lp_d;
    logic [PIC_LW-1:0]   win_q, win_d;
    logic                spur_q, spur_d;
    logic                ninta_q, ninta_d;

    logic [7:0]          masked_req;
    logic                req_valid, isr_valid, cand_valid;
    logic [PIC_LW-1:0]   req_lvl, isr_lvl;
    logic                fall, rise;
    logic [7:0]          isr_set, isr_clr;

    assign masked_req = IRR & ~IMR;

    pic_prio_rotate u_cand_prio (
        .req   (masked_req),
        .lp    (lp_q),
        .valid (req_valid),
        .lvl   (req_lvl)
    );

    pic_prio_rotate u_isr_prio (
        .req   (isr_q),
        .lp    (lp_q),
        .valid (isr_valid),
        .lvl   (isr_lvl)
    );

    // Fully nested: a request must outrank every level already in service
    assign cand_valid = req_valid &&
                        (!isr_valid || (prio_rank(req_lvl, lp_q) < prio_rank(isr_lvl, lp_q)));

    assign fall = ninta_q & ~NINTA;
    assign rise = ~ninta_q & NINTA;

    always_comb begin
        state_d   = state_q;
        int_d     = int_q;
        irr_clr_d = '0;
        vec_d     = vec_q;
        vec_oe_d  = vec_oe_q;
        lp_d      = lp_q;
        win_d     = win_q;
        spur_d    = spur_q;
        ninta_d   = NINTA;
        isr_set   = '0;
        isr_clr   = '0;

        case (state_q)
            ST_IDLE: begin
                if (cand_valid) begin
                    state_d = ST_REQ;
                    int_d   = 1'b1;
                end
            end
            ST_REQ: begin
                if (fall) begin
                    state_d = ST_ACK1;
                    int_d   = 1'b0;
                    if (cand_valid) begin
                        win_d     = req_lvl;
                        spur_d    = 1'b0;
                        isr_set   = 8'b1 << req_lvl;
                        irr_clr_d = 8'b1 << req_lvl;
                    end else begin
                        win_d  = SPUR_LVL;
                        spur_d = 1'b1;
                    end
                end else if (!cand_valid) begin
                    state_d = ST_IDLE;
                    int_d   = 1'b0;
                end
            end
            ST_ACK1: begin
                if (rise) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (fall) begin
                    state_d  = ST_ACK2;
                    vec_d    = {VEC_BASE, win_q};
                    vec_oe_d = 1'b1;
                end
            end
            ST_ACK2: begin
                if (rise) begin
                    state_d  = ST_IDLE;
                    vec_oe_d = 1'b0;
                    if (AEOI && !spur_q) begin
                        isr_clr = 8'b1 << win_q;
                        if (ROT_EN) begin
                            lp_d = win_q;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Non-specific EOI targets the pre-update ISR; a same-cycle INTA set still wins
        if (EOI_STB) begin
            if (EOI_SPEC) begin
                isr_clr = isr_clr | (8'b1 << EOI_LVL);
                if (ROT_EN) begin
                    lp_d = EOI_LVL;
                end
            end else if (isr_valid) begin
                isr_clr = isr_clr | (8'b1 << isr_lvl);
                if (ROT_EN) begin
                    lp_d = isr_lvl;
                end
            end
        end

        isr_d = (isr_q & ~isr_clr) | isr_set;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            int_q     <= 1'b0;
            isr_q     <= '0;
            irr_clr_q <= '0;
            vec_q     <= '0;
            vec_oe_q  <= 1'b0;
            lp_q      <= 3'd7;
            win_q     <= '0;
            spur_q    <= 1'b0;
            ninta_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            int_q     <= int_d;
            isr_q     <= isr_d;
            irr_clr_q <= irr_clr_d;
            vec_q     <= vec_d;
            vec_oe_q  <= vec_oe_d;
            lp_q      <= lp_d;
            win_q     <= win_d;
            spur_q    <= spur_d;
            ninta_q   <= ninta_d;
        end
    end

    assign INT     = int_q;
    assign ISR     = isr_q;
    assign IRR_CLR = irr_clr_q;
    assign VEC     = vec_q;
    assign VEC_OE  = vec_oe_q;

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// tb/tb_pic_ack_sequencer.sv - self-checking bench for pic_ack_sequencer
module tb_pic_ack_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irr, imr;
    logic       ninta, eoi_stb, eoi_spec, aeoi, rot_en;
    logic [2:0] eoi_lvl;
    logic [4:0] vec_base;
    logic       int_o, vec_oe;
    logic [7:0] isr, irr_clr, vec;

    int tests = 0;
    int fails = 0;

    logic [7:0] m_isr;
    int         m_lp;

    pic_ack_sequencer dut (
        .CLK(clk), .RST(rst), .IRR(irr), .IMR(imr), .NINTA(ninta),
        .EOI_STB(eoi_stb), .EOI_SPEC(eoi_spec), .EOI_LVL(eoi_lvl),
        .AEOI(aeoi), .ROT_EN(rot_en), .VEC_BASE(vec_base),
        .INT(int_o), .ISR(isr), .IRR_CLR(irr_clr), .VEC(vec), .VEC_OE(vec_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ninta = 1'b1; irr = '0; imr = '0;
        eoi_stb = 1'b0; eoi_spec = 1'b0; eoi_lvl = '0; aeoi = 1'b0; rot_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Priority rank of a level: 0 is the level right after the lowest-priority pointer
    function automatic int rank_of(int lvl, int lp);
        return (lvl - lp - 1 + 16) % 8;
    endfunction

    function automatic int top_lvl(logic [7:0] bits, int lp);
        int best = -1;
        for (int l = 0; l < 8; l++)
            if (bits[l] && (best < 0 || rank_of(l, lp) < rank_of(best, lp)))
                best = l;
        return best;
    endfunction

    function automatic int model_cand(logic [7:0] req, logic [7:0] isr_v, int lp);
        int c = top_lvl(req, lp);
        int t = top_lvl(isr_v, lp);
        if (c < 0) return -1;
        if (t >= 0 && rank_of(c, lp) >= rank_of(t, lp)) return -1;
        return c;
    endfunction

    // Two-pulse acknowledge; emulates the IRR block clearing the acknowledged bit
    task automatic run_inta(input logic drop_irr, input logic eoi_now, input logic spec,
                            input logic [2:0] lvl,
                            output logic int_fall, output logic [7:0] clr_obs,
                            output logic [7:0] isr_fall, output logic [7:0] vec_obs,
                            output logic oe_obs, output logic oe_hold, output logic oe_after);
        ninta = 1'b0;
        if (drop_irr) irr = '0;
        if (eoi_now) begin
            eoi_stb = 1'b1; eoi_spec = spec; eoi_lvl = lvl;
        end
        tick();
        eoi_stb = 1'b0;
        int_fall = int_o; clr_obs = irr_clr; isr_fall = isr;
        irr = irr & ~irr_clr;
        tick();
        ninta = 1'b1;
        tick();
        ninta = 1'b0;
        tick();
        vec_obs = vec; oe_obs = vec_oe;
        tick();
        oe_hold = vec_oe;
        ninta = 1'b1;
        tick();
        oe_after = vec_oe;
    endtask

    logic       r_int, r_oe, r_hold, r_after;
    logic [7:0] r_clr, r_isr, r_vec;

    task automatic test_reset();
        do_reset();
        tests++; if (int_o !== 1'b0) begin fails++; $display("FAIL reset_int got=%b exp=0", int_o); end
        tests++; if (isr !== 8'h00) begin fails++; $display("FAIL reset_isr got=%h exp=00", isr); end
        tests++; if (irr_clr !== 8'h00) begin fails++; $display("FAIL reset_irr_clr got=%h exp=00", irr_clr); end
        tests++; if (vec !== 8'h00 || vec_oe !== 1'b0) begin fails++; $display("FAIL reset_vec got=%h/%b exp=00/0", vec, vec_oe); end
    endtask

    task automatic test_basic_ack();
        do_reset();
        vec_base = 5'h08; irr = 8'h04;
        tick();
        tests++; if (int_o !== 1'b1) begin fails++; $display("FAIL basic_int got=%b exp=1", int_o); end
        run_inta(1'b0, 1'b0, 1'b0, 3'd0, r_int, r_clr, r_isr, r_vec, r_oe, r_hold, r_after);
        tests++; if (r_int !== 1'b0) begin fails++; $display("FAIL basic_int_drop got=%b exp=0", r_int); end
        tests++; if (r_clr !== 8'h04) begin fails++; $display("FAIL basic_irr_clr got=%h exp=04", r_clr); end
        tests++; if (r_isr !== 8'h04) begin fails++; $display("FAIL basic_isr got=%h exp=04", r_isr); end
        tests++; if (r_vec !== 8'h42 || r_oe !== 1'b1 || r_hold !== 1'b1) begin fails++; $display("FAIL basic_vec got=%h oe=%b hold=%b exp=42/1/1", r_vec, r_oe, r_hold); end
        tests++; if (r_after !== 1'b0) begin fails++; $display("FAIL basic_oe_release got=%b exp=0", r_after); end
        tests++; if (irr_clr !== 8'h00) begin fails++; $display("FAIL basic_irr_clr_pulse got=%h exp=00", irr_clr); end
    endtask

    task automatic test_nested();
        do_reset();
        vec_base = 5'h08; irr = 8'h81;
        tick();
        run_inta(1'b0, 1'b0, 1'b0, 3'd0, r_int, r_clr, r_isr, r_vec, r_oe, r_hold, r_after);
        tests++; if (r_vec !== {5'h08, 3'd0} || r_isr !== 8'h01) begin fails++; $display("FAIL nested_ir0 got vec=%h isr=%h exp=40/01", r_vec, r_isr); end
        irr = 8'h02;
        tick(); tick();
        tests++; if (int_o !== 1'b0) begin fails++; $display("FAIL nested_block got=%b exp=0", int_o); end
        eoi_stb = 1'b1; eoi_spec = 1'b0;
        tick();
        eoi_stb = 1'b0;
        tests++; if (isr !== 8'h00) begin fails++; $display("FAIL nested_eoi got=%h exp=00", isr); end
        tick();
        tests++; if (int_o !== 1'b1) begin fails++; $display("FAIL nested_int_ir1 got=%b exp=1", int_o); end
        run_inta(1'b0, 1'b0, 1'b0, 3'd0, r_int, r_clr, r_isr, r_vec, r_oe, r_hold, r_after);
        tests++; if (r_vec !== {5'h08, 3'd1} || r_clr !== 8'h02) begin fails++; $display("FAIL nested_ir1 got vec=%h clr=%h exp=41/02", r_vec, r_clr); end
    endtask

    task automatic test_withdraw();
        do_reset();
        irr = 8'h10;
        tick();
        tests++; if (int_o !== 1'b1) begin fails++; $display("FAIL withdraw_raise got=%b exp=1", int_o); end
        imr = 8'h10;
        tick();
        tests++; if (int_o !== 1'b0) begin fails++; $display("FAIL withdraw_drop got=%b exp=0", int_o); end
        imr = 8'h00; irr = 8'h00;
    endtask

    task automatic test_aeoi_rotate();
        do_reset();
        vec_base = 5'h08; aeoi = 1'b1; rot_en = 1'b1; irr = 8'h08;
        tick();
        run_inta(1'b0, 1'b0, 1'b0, 3'd0, r_int, r_clr, r_isr, r_vec, r_oe, r_hold, r_after);
        tests++; if (r_isr !== 8'h08 || isr !== 8'h00) begin fails++; $display("FAIL aeoi_clear got fall=%h end=%h exp=08/00", r_isr, isr); end
        irr = 8'h11;
        tick();
        run_inta(1'b0, 1'b0, 1'b0, 3'd0, r_int, r_clr, r_isr, r_vec, r_oe, r_hold, r_after);
        tests++; if (r_vec !== {5'h08, 3'd4}) begin fails++; $display("FAIL rotate_ir4 got=%h exp=%h", r_vec, {5'h08, 3'd4}); end
        aeoi = 1'b0; rot_en = 1'b0; irr = 8'h00;
    endtask

    task automatic test_spurious();
        do_reset();
        vec_base = 5'h15; irr = 8'h40;
        tick();
        run_inta(1'b0, 1'b0, 1'b0, 3'd0, r_int, r_clr, r_isr, r_vec, r_oe, r_hold, r_after);
        irr = 8'h20;
        tick();
        tests++; if (int_o !== 1'b1) begin fails++; $display("FAIL spur_int got=%b exp=1", int_o); end
        run_inta(1'b1, 1'b0, 1'b0, 3'd0, r_int, r_clr, r_isr, r_vec, r_oe, r_hold, r_after);
        tests++; if (r_isr !== 8'h40 || isr !== 8'h40) begin fails++; $display("FAIL spur_isr got=%h/%h exp=40", r_isr, isr); end
        tests++; if (r_clr !== 8'h00) begin fails++; $display("FAIL spur_irr_clr got=%h exp=00", r_clr); end
        tests++; if (r_vec !== {5'h15, 3'd7} || r_oe !== 1'b1) begin fails++; $display("FAIL spur_vec got=%h/%b exp=%h/1", r_vec, r_oe, {5'h15, 3'd7}); end
    endtask

    task automatic test_same_cycle_eoi();
        do_reset();
        irr = 8'h04;
        tick();
        run_inta(1'b0, 1'b1, 1'b1, 3'd2, r_int, r_clr, r_isr, r_vec, r_oe, r_hold, r_after);
        tests++; if (r_isr !== 8'h04) begin fails++; $display("FAIL eoi_same_bit got=%h exp=04", r_isr); end
        do_reset();
        irr = 8'h40;
        tick();
        run_inta(1'b0, 1'b0, 1'b0, 3'd0, r_int, r_clr, r_isr, r_vec, r_oe, r_hold, r_after);
        irr = 8'h04;
        tick();
        run_inta(1'b0, 1'b1, 1'b1, 3'd6, r_int, r_clr, r_isr, r_vec, r_oe, r_hold, r_after);
        tests++; if (r_isr !== 8'h04) begin fails++; $display("FAIL eoi_diff_bit got=%h exp=04", r_isr); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        vec_base = 5'h08; aeoi = 1'b1; rot_en = 1'b1; irr = 8'h08;
        tick();
        run_inta(1'b0, 1'b0, 1'b0, 3'd0, r_int, r_clr, r_isr, r_vec, r_oe, r_hold, r_after);
        aeoi = 1'b0; rot_en = 1'b0; irr = 8'h04;
        tick();
        ninta = 1'b0;
        tick();
        irr = 8'h00;
        tick();
        ninta = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if (int_o !== 1'b0 || vec_oe !== 1'b0 || isr !== 8'h00) begin fails++; $display("FAIL rst_mid got int=%b oe=%b isr=%h exp=0/0/00", int_o, vec_oe, isr); end
        for (int k = 0; k < 3; k++) begin
            ninta = 1'b0; tick(); tick();
            tests++; if (vec_oe !== 1'b0 || int_o !== 1'b0) begin fails++; $display("FAIL stray_ninta got oe=%b int=%b exp=0/0", vec_oe, int_o); end
            ninta = 1'b1; tick();
        end
        irr = 8'h11;
        tick();
        run_inta(1'b0, 1'b0, 1'b0, 3'd0, r_int, r_clr, r_isr, r_vec, r_oe, r_hold, r_after);
        tests++; if (r_vec !== {5'h08, 3'd0}) begin fails++; $display("FAIL rst_lp got=%h exp=%h", r_vec, {5'h08, 3'd0}); end
        irr = 8'h00;
    endtask

    task automatic test_random();
        int c, t;
        logic [2:0] cl;
        do_reset();
        m_isr = '0; m_lp = 7;
        vec_base = 5'h1a;
        for (int it = 0; it < 60; it++) begin
            aeoi = 1'($urandom_range(0, 1));
            rot_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                eoi_stb = 1'b1;
                eoi_spec = 1'($urandom_range(0, 1));
                eoi_lvl = 3'($urandom_range(0, 7));
                tick();
                eoi_stb = 1'b0;
                if (eoi_spec) begin
                    m_isr[eoi_lvl] = 1'b0;
                    if (rot_en) m_lp = int'(eoi_lvl);
                end else begin
                    t = top_lvl(m_isr, m_lp);
                    if (t >= 0) begin
                        m_isr[t] = 1'b0;
                        if (rot_en) m_lp = t;
                    end
                end
                tests++; if (isr !== m_isr) begin fails++; $display("FAIL rand_eoi it=%0d got=%h exp=%h", it, isr, m_isr); end
            end
            irr = 8'($urandom);
            imr = 8'($urandom) & 8'($urandom);
            c = model_cand(irr & ~imr, m_isr, m_lp);
            tick();
            if (c < 0) begin
                tick();
                tests++; if (int_o !== 1'b0) begin fails++; $display("FAIL rand_noint it=%0d got=%b exp=0", it, int_o); end
            end else begin
                cl = c[2:0];
                tests++; if (int_o !== 1'b1) begin fails++; $display("FAIL rand_int it=%0d got=%b exp=1", it, int_o); end
                run_inta(1'b0, 1'b0, 1'b0, 3'd0, r_int, r_clr, r_isr, r_vec, r_oe, r_hold, r_after);
                irr = 8'h00;
                m_isr[c] = 1'b1;
                tests++; if (r_clr !== (8'h01 << c) || r_isr !== m_isr) begin fails++; $display("FAIL rand_ack it=%0d got clr=%h isr=%h exp=%h/%h", it, r_clr, r_isr, 8'h01 << c, m_isr); end
                tests++; if (r_vec !== {vec_base, cl} || r_oe !== 1'b1 || r_after !== 1'b0) begin fails++; $display("FAIL rand_vec it=%0d got=%h oe=%b/%b exp=%h", it, r_vec, r_oe, r_after, {vec_base, cl}); end
                if (aeoi) begin
                    m_isr[c] = 1'b0;
                    if (rot_en) m_lp = c;
                end
                tests++; if (isr !== m_isr) begin fails++; $display("FAIL rand_isr_end it=%0d got=%h exp=%h", it, isr, m_isr); end
            end
            irr = 8'h00;
        end
    endtask

    initial begin
        rst = 1'b1; irr = '0; imr = '0; ninta = 1'b1; eoi_stb = 1'b0; eoi_spec = 1'b0;
        eoi_lvl = '0; aeoi = 1'b0; rot_en = 1'b0; vec_base = '0;
        test_reset();
        test_basic_ack();
        test_nested();
        test_withdraw();
        test_aeoi_rotate();
        test_spurious();
        test_same_cycle_eoi();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
